// File: rtl/nonce_sweep_scheduler_pkg.sv
// Shared definitions for the nonce sweep scheduler: sweep FSM encoding, default sizing,
// and the SHA-256 round-constant table used by the hashing lanes.
package nonce_sweep_scheduler_pkg;

  localparam int NUM_CORES_DEF = 16;
  localparam int NONCE_W_DEF   = 32;

  typedef logic [1:0] sweep_state_t;

  localparam sweep_state_t ST_IDLE   = 2'd0;
  localparam sweep_state_t ST_LAUNCH = 2'd1;
  localparam sweep_state_t ST_WAIT   = 2'd2;
  localparam sweep_state_t ST_EVAL   = 2'd3;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/nonce_sweep_scheduler_lane_match_encoder.sv
// Combinational match detector: flags enabled lanes whose captured hash word 0 is below
// the target and reports the lowest such lane (lowest nonce wins).
module nonce_sweep_scheduler_lane_match_encoder
  import nonce_sweep_scheduler_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int NONCE_W   = NONCE_W_DEF,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0]         i_lane_en,
  input  logic [NUM_CORES*NONCE_W-1:0] i_hash_cap,
  input  logic [NONCE_W-1:0]           i_target,
  output logic                         o_hit,
  output logic [IDX_W-1:0]             o_idx
);

  logic [NUM_CORES-1:0] w_match;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_match
      assign w_match[gi] = i_lane_en[gi] && (i_hash_cap[gi*NONCE_W +: NONCE_W] < i_target);
    end
  endgenerate

  assign o_hit = |w_match;

  // Scan from the top down so the lowest matching lane is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Launches batches of NUM_CORES nonces on the lane array, collects skewed per-lane results,
// and stops on the lowest matching nonce or when the requested range is used up.
module nonce_sweep_scheduler
  import nonce_sweep_scheduler_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int NONCE_W   = NONCE_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NONCE_W-1:0]           nonce_base,
  input  logic [NONCE_W-1:0]           nonce_count,
  input  logic [NONCE_W-1:0]           target,
  output logic                         core_start,
  output logic [NONCE_W-1:0]           core_nonce_base,
  output logic [NUM_CORES-1:0]         core_lane_en,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES*NONCE_W-1:0] core_hash0,
  output logic                         done,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic [15:0]                  batches
);

  localparam int                 IDX_W    = $clog2(NUM_CORES);
  localparam logic [NONCE_W-1:0] LP_CORES = NONCE_W'(NUM_CORES);

  sweep_state_t                 r_state;
  logic [NONCE_W-1:0]           r_base;
  logic [NONCE_W-1:0]           r_remaining;
  logic [NONCE_W-1:0]           r_target;
  logic [NONCE_W-1:0]           r_found_nonce;
  logic [NUM_CORES-1:0]         r_lane_en;
  logic [NUM_CORES-1:0]         r_sticky;
  logic [NUM_CORES*NONCE_W-1:0] r_hash_cap;
  logic                         r_found;
  logic [15:0]                  r_batches;

  logic [NONCE_W-1:0]   w_batch_len;
  logic [NONCE_W-1:0]   w_rem_after;
  logic [NONCE_W-1:0]   w_rem_launch;
  logic [NUM_CORES-1:0] w_mask_launch;
  logic [NUM_CORES-1:0] w_capture;
  logic                 w_all_done;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;

  // Lanes in a batch equal its popcount, so the decrement never underflows.
  assign w_batch_len  = (r_remaining >= LP_CORES) ? LP_CORES : r_remaining;
  assign w_rem_after  = r_remaining - w_batch_len;
  assign w_rem_launch = (r_state == ST_IDLE) ? nonce_count : w_rem_after;
  assign w_all_done   = &(r_sticky | ~r_lane_en);

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
      assign w_mask_launch[gi] = (w_rem_launch > NONCE_W'(gi));
      assign w_capture[gi]     = (r_state == ST_WAIT) && core_done[gi] && r_lane_en[gi];
    end
  endgenerate

  nonce_sweep_scheduler_lane_match_encoder #(
    .NUM_CORES (NUM_CORES),
    .NONCE_W   (NONCE_W),
    .IDX_W     (IDX_W)
  ) u_match (
    .i_lane_en  (r_lane_en),
    .i_hash_cap (r_hash_cap),
    .i_target   (r_target),
    .o_hit      (w_hit),
    .o_idx      (w_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky   <= '0;
      r_hash_cap <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_capture[i]) begin
          r_sticky[i]                       <= 1'b1;
          r_hash_cap[i*NONCE_W +: NONCE_W] <= core_hash0[i*NONCE_W +: NONCE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_remaining   <= '0;
      r_target      <= '0;
      r_found_nonce <= '0;
      r_lane_en     <= '0;
      r_found       <= 1'b0;
      r_batches     <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
      r_found <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_base        <= nonce_base;
            r_remaining   <= nonce_count;
            r_target      <= target;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_batches     <= '0;
            if (nonce_count != '0) begin
              r_state   <= ST_LAUNCH;
              r_lane_en <= w_mask_launch;
            end
          end
        end
        ST_LAUNCH: begin
          if (r_batches != 16'hFFFF) r_batches <= r_batches + 16'd1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_all_done) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (w_hit) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_base + NONCE_W'(w_idx);
            r_state       <= ST_IDLE;
          end else begin
            r_remaining <= w_rem_after;
            r_base      <= r_base + LP_CORES;
            if (w_rem_after == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_LAUNCH;
              r_lane_en <= w_mask_launch;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done            = (r_state == ST_IDLE);
  assign core_start      = (r_state == ST_LAUNCH);
  assign core_nonce_base = r_base;
  assign core_lane_en    = r_lane_en;
  assign found           = r_found;
  assign found_nonce     = r_found_nonce;
  assign batches         = r_batches;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Bench for nonce_sweep_scheduler: emulated lane array with random skew, hashes per nonce
// offset held in a table, expected results derived from a first-match scan of that table.
module tb_nonce_sweep_scheduler;
  localparam int N = 16;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           abort;
  logic [W-1:0]   nonce_base;
  logic [W-1:0]   nonce_count;
  logic [W-1:0]   target;
  logic           core_start;
  logic [W-1:0]   core_nonce_base;
  logic [N-1:0]   core_lane_en;
  logic [N-1:0]   core_done;
  logic [N*W-1:0] core_hash0;
  logic           done;
  logic           found;
  logic [W-1:0]   found_nonce;
  logic [15:0]    batches;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] hv [0:255];

  always #5 clk = ~clk;

  nonce_sweep_scheduler #(.NUM_CORES(N), .NONCE_W(W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .nonce_base      (nonce_base),
    .nonce_count     (nonce_count),
    .target          (target),
    .core_start      (core_start),
    .core_nonce_base (core_nonce_base),
    .core_lane_en    (core_lane_en),
    .core_done       (core_done),
    .core_hash0      (core_hash0),
    .done            (done),
    .found           (found),
    .found_nonce     (found_nonce),
    .batches         (batches)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic fill_nomatch();
    for (int k = 0; k < 256; k++) hv[k] = 32'h8000_0000 | $urandom;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 256; k++) hv[k] = $urandom;
  endtask

  // Called at a negedge; runs one complete sweep while acting as the lane array.
  task automatic run_sweep(input logic [31:0] b, input int cnt, input logic [31:0] tgt,
                           input bit skew);
    int          first, exp_b, launches, cyc, last_drive, rem, limit;
    int          t [N];
    bit          exp_f;
    logic [31:0] exp_n;
    logic [N-1:0] mask, cur_en;

    first = -1;
    for (int k = 0; k < cnt; k++) if (first < 0 && hv[k] < tgt) first = k;
    exp_f = (first >= 0);
    exp_n = exp_f ? b + 32'(first) : 32'h0;
    exp_b = exp_f ? first / N + 1 : (cnt + N - 1) / N;

    nonce_base = b; nonce_count = 32'(cnt); target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    launches = 0; cyc = 0; last_drive = -3; cur_en = '0;
    t = '{default: 0};
    limit = (cnt == 0) ? 6 : 2000;
    while (cyc < limit && !(launches > 0 && done)) begin
      core_done  = '0;
      core_hash0 = '0;
      if (core_start) begin
        rem  = cnt - launches * N;
        mask = (rem >= N) ? '1 : N'((1 << rem) - 1);
        check("launch_base", core_nonce_base, b + 32'(launches * N));
        check("launch_mask", 32'(core_lane_en), 32'(mask));
        check("launch_latency", 32'(cyc), 32'(last_drive + 3));
        cur_en = mask;
        for (int i = 0; i < N; i++)
          t[i] = mask[i] ? (skew ? 1 + 2 * i : int'($urandom_range(1, 6))) : 0;
        launches++;
        core_done = N'($urandom);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (t[i] > 0) begin
            t[i]--;
            if (t[i] == 0) begin
              core_done[i]          = 1'b1;
              core_hash0[i*W +: W]  = hv[(launches - 1) * N + i];
              last_drive            = cyc;
            end
          end else if (!cur_en[i]) begin
            core_done[i] = ($urandom_range(0, 1) == 1);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    core_done  = '0;
    core_hash0 = '0;
    check("end_done", 32'(done), 32'd1);
    if (cnt > 0) check("done_latency", 32'(cyc), 32'(last_drive + 3));
    check("found", 32'(found), 32'(exp_f));
    check("found_nonce", found_nonce, exp_n);
    check("batches", 32'(batches), 32'(exp_b));
    check("launch_count", 32'(launches), 32'(exp_b));
    $display("sweep base=%08h count=%0d target=%08h -> found=%0d nonce=%08h batches=%0d",
             b, cnt, tgt, found, found_nonce, batches);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_base = '0; nonce_count = '0; target = '0;
    core_done = '0; core_hash0 = '0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd1);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_lane_en", 32'(core_lane_en), 32'd0);
    check("rst_nonce_base", core_nonce_base, 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_batches", 32'(batches), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // three batches, last one partial, nothing can match a zero target
    fill_nomatch();
    run_sweep(32'h100, 40, 32'h0, 1'b0);

    // lanes 5 and 9 of batch 2 match; lane 5 wins
    fill_nomatch();
    hv[21] = 32'h10; hv[25] = 32'h10;
    run_sweep(32'h0, 64, 32'h100, 1'b0);

    // empty range after a found sweep: found must clear, no launch
    run_sweep(32'h55, 0, 32'hFFFF_FFFF, 1'b0);

    // nonce wraps through zero
    fill_nomatch();
    hv[10] = 32'h5;
    run_sweep(32'hFFFF_FFF8, 16, 32'h100, 1'b0);

    // partial batch with staggered done on lanes 0..3 only
    fill_nomatch();
    run_sweep(32'h2000, 20, 32'h1000, 1'b1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_sweep($urandom, int'($urandom_range(1, 100)), 32'h0400_0000, r[0]);
    end

    // abort while waiting on the lanes
    fill_nomatch();
    nonce_base = 32'h0; nonce_count = 32'd64; target = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_launch", 32'(core_start), 32'd1);
    @(negedge clk);
    check("abort_in_wait", 32'(done), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done", 32'(done), 32'd1);
    check("abort_found", 32'(found), 32'd0);
    check("abort_core_start", 32'(core_start), 32'd0);
    check("abort_batches", 32'(batches), 32'd1);
    $display("abort in WAIT -> done=%0d batches=%0d", done, batches);

    // start and abort together in IDLE: nothing captured, found kept
    fill_nomatch();
    hv[3] = 32'h1;
    run_sweep(32'h4000, 16, 32'h100, 1'b0);
    nonce_count = 32'd16; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start", 32'(core_start), 32'd0);
    check("idle_abort_done", 32'(done), 32'd1);
    check("idle_abort_found", 32'(found), 32'd1);
    @(negedge clk);
    check("idle_abort_start2", 32'(core_start), 32'd0);
    $display("start+abort in IDLE -> core_start=%0d found=%0d", core_start, found);

    // asynchronous reset during LAUNCH
    nonce_base = 32'h1234; nonce_count = 32'd40; target = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("areset_launch", 32'(core_start), 32'd1);
    reset_n = 1'b0;
    #1;
    check("areset_done", 32'(done), 32'd1);
    check("areset_core_start", 32'(core_start), 32'd0);
    check("areset_lane_en", 32'(core_lane_en), 32'd0);
    check("areset_nonce_base", core_nonce_base, 32'd0);
    check("areset_found", 32'(found), 32'd0);
    check("areset_found_nonce", found_nonce, 32'd0);
    check("areset_batches", 32'(batches), 32'd0);
    $display("reset in LAUNCH -> done=%0d lane_en=%04h", done, core_lane_en);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
